// File: rtl/lift_scan_ctrl.sv
// lift_scan_ctrl: SCAN-scheduled lift controller with a registered pending-request
// bitmap, per-floor travel timing and a timed door phase.
// Optional feature: define LIFT_EMERG_EN to add the in_emerg recall-to-floor-0 input.
module lift_scan_ctrl #(
  parameter int unsigned FLOORS     = 8,
  parameter int unsigned FW         = $clog2(FLOORS),
  parameter int unsigned TRAVEL_CYC = 4,
  parameter int unsigned DOOR_CYC   = 3
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_req_vld,
  input  logic [FW-1:0]     in_req_f,
`ifdef LIFT_EMERG_EN
  input  logic              in_emerg,
`endif
  output logic [FW-1:0]     o_f,
  output logic              o_r,
  output logic [1:0]        o_dir,
  output logic              o_door,
  output logic [FLOORS-1:0] o_pend
);

  localparam int unsigned TW  = $clog2(TRAVEL_CYC + 1);
  localparam int unsigned DW  = $clog2(DOOR_CYC + 1);
  localparam int unsigned FW1 = FW + 1;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t            state, state_n;
  logic [FW-1:0]     f_n;
  logic [1:0]        dir_n;
  logic              r_n;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic [DW-1:0]     dcnt, dcnt_n;
  logic [FLOORS-1:0] pend_n, set_m, clr_m;
  logic              req_ok, up_any, dn_any, go_up, ahead, behind;

  // Pending requests strictly above / strictly below the current floor.
  always_comb begin
    up_any = 1'b0;
    dn_any = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (i > 32'(o_f)) up_any = up_any | o_pend[i];
      if (i < 32'(o_f)) dn_any = dn_any | o_pend[i];
    end
  end

  // Next-state, next-output and pending-bitmap update.
  always_comb begin
    state_n = state;
    f_n     = o_f;
    dir_n   = o_dir;
    r_n     = 1'b0;
    tcnt_n  = tcnt;
    dcnt_n  = dcnt;
    clr_m   = '0;
    req_ok  = in_req_vld && ({1'b0, in_req_f} < FW1'(FLOORS));
    set_m   = req_ok ? (FLOORS'(1) << in_req_f) : '0;
    // An idle cab has no heading; treat it as up so ties favour upward travel.
    go_up   = (o_dir != DIR_DN);
    ahead   = go_up ? up_any : dn_any;
    behind  = go_up ? dn_any : up_any;

    case (state)
      IDLE: begin
        dir_n = DIR_IDLE;
        if (o_pend[o_f]) begin
          state_n = DOOR;
          r_n     = 1'b1;
          dcnt_n  = '0;
          clr_m   = FLOORS'(1) << o_f;
        end else if (up_any) begin
          state_n = MOVE;
          dir_n   = DIR_UP;
          tcnt_n  = '0;
        end else if (dn_any) begin
          state_n = MOVE;
          dir_n   = DIR_DN;
          tcnt_n  = '0;
        end
      end
      MOVE: begin
        if (tcnt == TW'(TRAVEL_CYC - 1)) begin
          tcnt_n = '0;
          f_n    = (o_dir == DIR_DN) ? (o_f - FW'(1)) : (o_f + FW'(1));
          if (o_pend[f_n]) begin
            state_n = DOOR;
            r_n     = 1'b1;
            dcnt_n  = '0;
            clr_m   = FLOORS'(1) << f_n;
          end
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      DOOR: begin
        if (req_ok && (in_req_f == o_f)) begin
          // Hall call at the open door: keep it open, never latch the bit.
          dcnt_n = '0;
          set_m  = '0;
        end else if (dcnt == DW'(DOOR_CYC - 1)) begin
          tcnt_n = '0;
          if (ahead) begin
            state_n = MOVE;
            dir_n   = go_up ? DIR_UP : DIR_DN;
          end else if (behind) begin
            state_n = MOVE;
            dir_n   = go_up ? DIR_DN : DIR_UP;
          end else begin
            state_n = IDLE;
            dir_n   = DIR_IDLE;
          end
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef LIFT_EMERG_EN
    // Emergency recall: drop all calls, run down to floor 0 and hold the door open.
    if (in_emerg) begin
      set_m  = '0;
      clr_m  = '1;
      r_n    = 1'b0;
      dcnt_n = '0;
      tcnt_n = '0;
      f_n    = o_f;
      dir_n  = DIR_DN;
      if (o_f == '0) begin
        state_n = DOOR;
        r_n     = (state != DOOR);
        dir_n   = o_dir;
      end else if (state != MOVE) begin
        state_n = MOVE;
      end else if (tcnt == TW'(TRAVEL_CYC - 1)) begin
        f_n     = o_f - FW'(1);
        state_n = (f_n == '0) ? DOOR : MOVE;
        r_n     = (f_n == '0);
      end else begin
        state_n = MOVE;
        tcnt_n  = tcnt + TW'(1);
      end
    end else if (state == MOVE && state_n == MOVE && tcnt == TW'(TRAVEL_CYC - 1) &&
                 f_n == '0) begin
      // A downward run left over from a released recall parks at floor 0.
      state_n = DOOR;
      r_n     = 1'b1;
      dcnt_n  = '0;
    end
`endif

    pend_n = (o_pend | set_m) & ~clr_m;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state  <= IDLE;
      o_f    <= '0;
      o_r    <= 1'b0;
      o_dir  <= DIR_IDLE;
      o_door <= 1'b0;
      o_pend <= '0;
      tcnt   <= '0;
      dcnt   <= '0;
    end else begin
      state  <= state_n;
      o_f    <= f_n;
      o_r    <= r_n;
      o_dir  <= dir_n;
      o_door <= (state_n == DOOR);
      o_pend <= pend_n;
      tcnt   <= tcnt_n;
      dcnt   <= dcnt_n;
    end
  end

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// tb_lift_scan_ctrl: directed scenarios plus randomized traffic, every output
// compared each cycle against an event-level lift model.
module tb_lift_scan_ctrl;

  localparam int FLOORS     = 8;
  localparam int TRAVEL_CYC = 4;
  localparam int DOOR_CYC   = 3;

  localparam int PH_IDLE = 0;
  localparam int PH_MOVE = 1;
  localparam int PH_DOOR = 2;

  logic       clk = 1'b0;
  logic       rst_n, req_vld;
  logic [2:0] req_f;
  logic [2:0] f;
  logic       r, door;
  logic [1:0] dir;
  logic [7:0] pend;

  logic       rst5_n, vld5;
  logic [2:0] f5_in, f5;
  logic       r5, door5;
  logic [1:0] dir5;
  logic [4:0] pend5;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: floor position, heading (+1/-1/0), cycles left in phase.
  int m_phase, m_pos, m_dir, m_left;
  bit m_r;
  bit m_pend[FLOORS];

  int stops[$];
  int stop_dirs[$];

  always #5 clk = ~clk;

  lift_scan_ctrl #(.FLOORS(8), .TRAVEL_CYC(4), .DOOR_CYC(3)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_req_vld(req_vld), .in_req_f(req_f),
    .o_f(f), .o_r(r), .o_dir(dir), .o_door(door), .o_pend(pend)
  );

  lift_scan_ctrl #(.FLOORS(5), .TRAVEL_CYC(4), .DOOR_CYC(3)) dut5 (
    .in_clk(clk), .in_rst_n(rst5_n), .in_req_vld(vld5), .in_req_f(f5_in),
    .o_f(f5), .o_r(r5), .o_dir(dir5), .o_door(door5), .o_pend(pend5)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit pend_toward(input int d);
    for (int i = 0; i < FLOORS; i++)
      if (m_pend[i] && (i - m_pos) * d > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic longint dir_code(input int d);
    return (d > 0) ? 1 : (d < 0) ? 2 : 0;
  endfunction

  function automatic longint pend_word();
    longint w = 0;
    for (int i = 0; i < FLOORS; i++) if (m_pend[i]) w |= (longint'(1) << i);
    return w;
  endfunction

  task automatic model_update(input bit rst, input bit rv, input int rf);
    int clr = -1;
    bit absorb = 1'b0;
    int fwd;
    m_r = 1'b0;
    if (!rst) begin
      m_phase = PH_IDLE; m_pos = 0; m_dir = 0; m_left = 0;
      for (int i = 0; i < FLOORS; i++) m_pend[i] = 1'b0;
      return;
    end
    case (m_phase)
      PH_IDLE: begin
        if (m_pend[m_pos]) begin
          m_phase = PH_DOOR; m_left = DOOR_CYC; m_r = 1'b1; clr = m_pos;
        end else if (pend_toward(1)) begin
          m_phase = PH_MOVE; m_dir = 1; m_left = TRAVEL_CYC;
        end else if (pend_toward(-1)) begin
          m_phase = PH_MOVE; m_dir = -1; m_left = TRAVEL_CYC;
        end else begin
          m_dir = 0;
        end
      end
      PH_MOVE: begin
        m_left--;
        if (m_left == 0) begin
          m_pos  += m_dir;
          m_left  = TRAVEL_CYC;
          if (m_pend[m_pos]) begin
            m_phase = PH_DOOR; m_left = DOOR_CYC; m_r = 1'b1; clr = m_pos;
          end
        end
      end
      default: begin
        if (rv && rf == m_pos) begin
          m_left = DOOR_CYC; absorb = 1'b1;
        end else begin
          m_left--;
          if (m_left == 0) begin
            fwd = (m_dir < 0) ? -1 : 1;
            if (pend_toward(fwd)) begin
              m_phase = PH_MOVE; m_dir = fwd; m_left = TRAVEL_CYC;
            end else if (pend_toward(-fwd)) begin
              m_phase = PH_MOVE; m_dir = -fwd; m_left = TRAVEL_CYC;
            end else begin
              m_phase = PH_IDLE; m_dir = 0;
            end
          end
        end
      end
    endcase
    if (rv && rf < FLOORS && !absorb && rf != clr) m_pend[rf] = 1'b1;
    if (clr >= 0) m_pend[clr] = 1'b0;
  endtask

  task automatic compare_all();
    check("floor", f, m_pos);
    check("reached", r, m_r);
    check("dir", dir, dir_code(m_dir));
    check("door", door, (m_phase == PH_DOOR));
    check("pend", pend, pend_word());
  endtask

  // One clock edge: drive inputs, advance the model, compare just after the edge.
  task automatic tick(input bit rv, input int rf, input bit rst);
    rst_n   = rst;
    req_vld = rv;
    req_f   = 3'(rf);
    @(posedge clk);
    model_update(rst, rv, rf);
    #1;
    compare_all();
    req_vld = 1'b0;
  endtask

  initial begin
    int  cyc;
    bit  hit;

    rst_n = 1'b0; req_vld = 1'b0; req_f = '0;
    rst5_n = 1'b0; vld5 = 1'b0; f5_in = '0;

    // Reset with random request inputs.
    tick(1'($urandom % 2), int'($urandom % 8), 1'b0);
    tick(1'($urandom % 2), int'($urandom % 8), 1'b0);
    check("rst_f", f, 0);
    check("rst_pend", pend, 0);
    check("rst_dir", dir, 0);
    check("rst_door", door, 0);
    check("rst_r", r, 0);

    // Five-floor instance: out-of-range requests are ignored.
    rst5_n = 1'b1; vld5 = 1'b1; f5_in = 3'd7;
    tick(1'b0, 0, 1'b1);
    f5_in = 3'd5;
    tick(1'b0, 0, 1'b1);
    f5_in = 3'd6;
    tick(1'b0, 0, 1'b1);
    vld5 = 1'b0;
    tick(1'b0, 0, 1'b1);
    tick(1'b0, 0, 1'b1);
    check("oor_pend", pend5, 0);
    check("oor_dir", dir5, 0);
    check("oor_door", door5, 0);
    check("oor_f", f5, 0);
    vld5 = 1'b1; f5_in = 3'd4;
    tick(1'b0, 0, 1'b1);
    vld5 = 1'b0;
    check("f5_top_pend", pend5, 5'h10);
    tick(1'b0, 0, 1'b1);
    check("f5_top_dir", dir5, 1);

    // Single trip 0 -> 3.
    tick(1'b0, 0, 1'b0);
    tick(1'b1, 3, 1'b1);
    check("trip_pend", pend, 8'h08);
    for (int e = 1; e <= 16; e++) begin
      tick(1'b0, 0, 1'b1);
      if (e == 1)  check("trip_dir_e1", dir, 1);
      if (e == 5)  check("trip_f_e5", f, 1);
      if (e == 9)  check("trip_f_e9", f, 2);
      if (e == 12) check("trip_r_e12", r, 0);
      if (e == 13) begin check("trip_f_e13", f, 3); check("trip_r_e13", r, 1); end
      if (e == 14) check("trip_r_e14", r, 0);
      if (e == 15) check("trip_door_e15", door, 1);
      if (e == 16) begin
        check("trip_door_e16", door, 0);
        check("trip_dir_e16", dir, 0);
        check("trip_pend_e16", pend, 0);
      end
    end

    // SCAN ordering: 6 requested, then 4 and 1 while passing floor 2.
    tick(1'b0, 0, 1'b0);
    tick(1'b1, 6, 1'b1);
    hit = 1'b0;
    for (cyc = 0; cyc < 100 && !hit; cyc++) begin
      tick(1'b0, 0, 1'b1);
      hit = (f == 3'd2);
    end
    check("scan_reach2", hit, 1);
    tick(1'b1, 4, 1'b1);
    tick(1'b1, 1, 1'b1);
    hit = 1'b0;
    for (cyc = 0; cyc < 400 && !hit; cyc++) begin
      tick(1'b0, 0, 1'b1);
      if (r) begin stops.push_back(int'(f)); stop_dirs.push_back(int'(dir)); end
      hit = (!door && dir == 2'b00 && pend == '0);
    end
    check("scan_done", hit, 1);
    check("scan_nstops", stops.size(), 3);
    if (stops.size() == 3) begin
      check("scan_stop0", stops[0], 4);
      check("scan_stop1", stops[1], 6);
      check("scan_stop2", stops[2], 1);
      check("scan_dir0", stop_dirs[0], 1);
      check("scan_dir1", stop_dirs[1], 1);
      check("scan_dir2", stop_dirs[2], 2);
    end
    check("scan_dir_end", dir, 0);

    // Same-floor request and door extension.
    tick(1'b0, 0, 1'b0);
    tick(1'b1, 0, 1'b1);
    tick(1'b0, 0, 1'b1);
    check("same_door_e1", door, 1);
    check("same_r_e1", r, 1);
    check("same_f_e1", f, 0);
    tick(1'b0, 0, 1'b1);
    check("same_r_e2", r, 0);
    tick(1'b1, 0, 1'b1);
    check("same_pend_e3", pend, 0);
    tick(1'b0, 0, 1'b1);
    check("same_door_e4", door, 1);
    tick(1'b0, 0, 1'b1);
    check("same_door_e5", door, 1);
    tick(1'b0, 0, 1'b1);
    check("same_door_e6", door, 0);
    check("same_dir_e6", dir, 0);

    // Reset while moving up past floor 2 with floor 5 pending.
    tick(1'b0, 0, 1'b0);
    tick(1'b1, 5, 1'b1);
    hit = 1'b0;
    for (cyc = 0; cyc < 100 && !hit; cyc++) begin
      tick(1'b0, 0, 1'b1);
      hit = (f == 3'd2);
    end
    check("mid_reach2", hit, 1);
    check("mid_pend", pend, 8'h20);
    tick(1'b0, 0, 1'b0);
    check("mid_rst_f", f, 0);
    check("mid_rst_dir", dir, 0);
    check("mid_rst_pend", pend, 0);
    check("mid_rst_door", door, 0);
    for (int k = 0; k < 20; k++) tick(1'b0, 0, 1'b1);
    check("mid_still_f", f, 0);
    check("mid_still_dir", dir, 0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 4000; k++)
      tick(1'(($urandom % 5) == 0), int'($urandom % 8), 1'(($urandom % 400) != 0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
